// File: rtl/timing_generator_pkg.sv
// Shared definitions for the 6502 T-state sequencer: vector bit positions,
// interrupt-type bit positions, the T-state encoding and step helpers.
package timing_generator_pkg;

  localparam int TW    = 8;   // width of timing_IN / timing_OUT
  localparam int MAX_T = 6;   // highest T-state

  // timing_IN bit positions
  localparam int T0_BIT     = 0;
  localparam int T1_BIT     = 1;
  localparam int T2_BIT     = 2;
  localparam int T3_BIT     = 3;
  localparam int T4_BIT     = 4;
  localparam int T5_BIT     = 5;
  localparam int T6_BIT     = 6;
  localparam int TV_INT_SEQ = 7;

  // timing_OUT feedback bit positions
  localparam int FB_END  = 0;
  localparam int FB_SKIP = 1;

  // sig_interrupt bit positions; the winner vector uses the first three
  localparam int INT_NMI = 0;
  localparam int INT_IRQ = 1;
  localparam int INT_RST = 2;
  localparam int INT_BRK = 3;
  localparam int WIN_W   = 3;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } tstate_e;

  localparam tstate_e T_LAST = T6;

  // Plain single step; T_LAST wraps to T0 (forced end of instruction).
  function automatic tstate_e t_inc(input tstate_e t);
    case (t)
      T0:      t_inc = T1;
      T1:      t_inc = T2;
      T2:      t_inc = T3;
      T3:      t_inc = T4;
      T4:      t_inc = T5;
      T5:      t_inc = T6;
      default: t_inc = T0;
    endcase
  endfunction

  // Double step requested by SKIP; saturates at T_LAST instead of wrapping.
  function automatic tstate_e t_skip(input tstate_e t);
    case (t)
      T0:      t_skip = T2;
      T1:      t_skip = T3;
      T2:      t_skip = T4;
      T3:      t_skip = T5;
      default: t_skip = T_LAST;
    endcase
  endfunction

  // One-hot image of a T-state for timing_IN[6:0].
  function automatic logic [MAX_T:0] t_onehot(input tstate_e t);
    case (t)
      T0:      t_onehot = 7'b000_0001;
      T1:      t_onehot = 7'b000_0010;
      T2:      t_onehot = 7'b000_0100;
      T3:      t_onehot = 7'b000_1000;
      T4:      t_onehot = 7'b001_0000;
      T5:      t_onehot = 7'b010_0000;
      T6:      t_onehot = 7'b100_0000;
      default: t_onehot = 7'b000_0001;
    endcase
  endfunction

endpackage

// File: rtl/timing_generator_if.sv
// Bundle between the T-state sequencer (master) and random_control_block plus
// the pin/flag sources (slave side).
interface timing_generator_if;
  import timing_generator_pkg::*;

  logic          sig_RDY;
  logic          sig_R_NOT_W;
  logic [TW-1:0] timing_OUT;
  logic          nmi_n;
  logic          irq_n;
  logic          flag_I;
  logic [TW-1:0] timing_IN;
  logic [7:0]    sig_interrupt;
  logic          SYNC;

  modport master (
    input  sig_RDY, sig_R_NOT_W, timing_OUT, nmi_n, irq_n, flag_I,
    output timing_IN, sig_interrupt, SYNC
  );

  modport slave (
    output sig_RDY, sig_R_NOT_W, timing_OUT, nmi_n, irq_n, flag_I,
    input  timing_IN, sig_interrupt, SYNC
  );

endinterface

// File: rtl/timing_generator_interrupt_latch.sv
// NMI edge latch, pending-reset flag and the RESET > NMI > IRQ priority encoder.
// The sequencer pulses accept_i on the decision edge; the winning pend flag is
// cleared there. A new NMI edge on that same edge stays pending.
module timing_generator_interrupt_latch
  import timing_generator_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             nmi_n_i,
  input  logic             irq_n_i,
  input  logic             flag_i_i,
  input  logic             accept_i,
  output logic [WIN_W-1:0] winner_o
);

  logic nmi_q, nmi_d;
  logic nmi_pend_q, nmi_pend_d;
  logic reset_pend_q, reset_pend_d;
  logic irq_act_s;
  logic nmi_edge_s;

  assign irq_act_s  = ~irq_n_i & ~flag_i_i;
  assign nmi_edge_s = nmi_q & ~nmi_n_i;

  // Priority encoder: only registered pend flags and the live IRQ level compete.
  always_comb begin
    winner_o = 3'b000;
    if (reset_pend_q) begin
      winner_o[INT_RST] = 1'b1;
    end else if (nmi_pend_q) begin
      winner_o[INT_NMI] = 1'b1;
    end else if (irq_act_s) begin
      winner_o[INT_IRQ] = 1'b1;
    end else begin
      winner_o = 3'b000;
    end
  end

  // Next-state of the latches: clear on acceptance, a fresh NMI edge always sets.
  always_comb begin
    nmi_d        = nmi_n_i;
    nmi_pend_d   = (nmi_pend_q & ~(accept_i & winner_o[INT_NMI])) | nmi_edge_s;
    reset_pend_d = reset_pend_q & ~(accept_i & winner_o[INT_RST]);
  end

  // Latch registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nmi_q        <= 1'b1;
      nmi_pend_q   <= 1'b0;
      reset_pend_q <= 1'b1;
    end else begin
      nmi_q        <= nmi_d;
      nmi_pend_q   <= nmi_pend_d;
      reset_pend_q <= reset_pend_d;
    end
  end

endmodule

// File: rtl/timing_generator.sv
// 6502 T-state sequencer: one-hot timing vector, interrupt-sequence vector,
// RDY stalling on read cycles and SYNC. All outputs come straight from flops.
module timing_generator
  import timing_generator_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  timing_generator_if.master bus
);

  tstate_e          t_q, t_d;
  logic [TW-1:0]    timing_q, timing_d;
  logic [7:0]       sig_int_q, sig_int_d;
  logic             sync_q, sync_d;
  logic             stall_s;
  logic             accept_s;
  logic             end_req_s;
  logic             skip_req_s;
  logic [WIN_W-1:0] winner_s;
  logic             unused_fb_s;

  assign stall_s     = ~bus.sig_RDY & bus.sig_R_NOT_W;
  assign end_req_s   = bus.timing_OUT[FB_END];
  assign skip_req_s  = bus.timing_OUT[FB_SKIP];
  assign unused_fb_s = ^bus.timing_OUT[TW-1:FB_SKIP+1];

  timing_generator_interrupt_latch u_int_latch (
    .clk      (clk),
    .rst_n    (rst_n),
    .nmi_n_i  (bus.nmi_n),
    .irq_n_i  (bus.irq_n),
    .flag_i_i (bus.flag_I),
    .accept_i (accept_s),
    .winner_o (winner_s)
  );

  // T-state next-state: T0 always advances (and is the decision point), END beats SKIP.
  always_comb begin
    t_d      = t_q;
    accept_s = 1'b0;
    if (stall_s) begin
      t_d = t_q;
    end else if (t_q == T0) begin
      t_d      = T1;
      accept_s = 1'b1;
    end else if (end_req_s) begin
      t_d = T0;
    end else if (skip_req_s) begin
      t_d = t_skip(t_q);
    end else begin
      t_d = t_inc(t_q);
    end
  end

  // Output next-state: the interrupt vector and INT_SEQ change only on a decision edge.
  always_comb begin
    sig_int_d = sig_int_q;
    timing_d  = {timing_q[TV_INT_SEQ], t_onehot(t_d)};
    if (accept_s) begin
      if (|winner_s) begin
        sig_int_d                = 8'h00;
        sig_int_d[INT_BRK]       = 1'b1;
        sig_int_d[WIN_W-1:0]     = winner_s;
        timing_d[TV_INT_SEQ]     = 1'b1;
      end else begin
        sig_int_d                = 8'h00;
        timing_d[TV_INT_SEQ]     = 1'b0;
      end
    end else begin
      sig_int_d = sig_int_q;
    end
    sync_d = timing_d[T1_BIT];
  end

  // State and output registers; reset forces T0 and aborts any sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_q       <= T0;
      timing_q  <= 8'h01;
      sig_int_q <= 8'h00;
      sync_q    <= 1'b0;
    end else begin
      t_q       <= t_d;
      timing_q  <= timing_d;
      sig_int_q <= sig_int_d;
      sync_q    <= sync_d;
    end
  end

  assign bus.timing_IN     = timing_q;
  assign bus.sig_interrupt = sig_int_q;
  assign bus.SYNC          = sync_q;

endmodule

// File: tb/tb_timing_generator.sv
// Directed bench for timing_generator: every expected vector is a hand-computed constant.
module tb_timing_generator;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  timing_generator_if bus ();

  timing_generator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock, then compare timing_IN, sig_interrupt and SYNC.
  task automatic tick_check(input string tag, input logic [7:0] exp_t, input logic [7:0] exp_i);
    logic [7:0] e;
    e = exp_t;
    @(posedge clk);
    #1;
    check_eq({tag, ".timing"}, {8'h00, bus.timing_IN}, {8'h00, exp_t});
    check_eq({tag, ".sigint"}, {8'h00, bus.sig_interrupt}, {8'h00, exp_i});
    check_eq({tag, ".sync"}, {15'h0000, bus.SYNC}, {15'h0000, e[1]});
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    rst_n            = 1'b0;
    bus.sig_RDY      = 1'b1;
    bus.sig_R_NOT_W  = 1'b1;
    bus.timing_OUT   = 8'h00;
    bus.nmi_n        = 1'b1;
    bus.irq_n        = 1'b1;
    bus.flag_I       = 1'b1;

    // Reset and release, no feedback
    tick_check("rst", 8'h01, 8'h00);
    rst_n = 1'b1;
    tick_check("rs_t1", 8'h82, 8'h0C);
    tick_check("rs_t2", 8'h84, 8'h0C);
    tick_check("rs_t3", 8'h88, 8'h0C);
    tick_check("rs_t4", 8'h90, 8'h0C);
    tick_check("rs_t5", 8'hA0, 8'h0C);
    tick_check("rs_t6", 8'hC0, 8'h0C);
    tick_check("rs_t0", 8'h81, 8'h0C);
    tick_check("rs_end", 8'h02, 8'h00);

    // END in T2: two-cycle cadence
    tick_check("e_t2", 8'h04, 8'h00);
    bus.timing_OUT = 8'h01;
    tick_check("e_t0", 8'h01, 8'h00);
    bus.timing_OUT = 8'h00;
    tick_check("e_t1", 8'h02, 8'h00);

    // SKIP, saturation, SKIP+END, feedback ignored in T0 (bits 7:2 set too)
    tick_check("s_t2", 8'h04, 8'h00);
    tick_check("s_t3", 8'h08, 8'h00);
    bus.timing_OUT = 8'h02;
    tick_check("s_t5", 8'h20, 8'h00);
    tick_check("s_sat", 8'h40, 8'h00);
    bus.timing_OUT = 8'h00;
    tick_check("s_fend", 8'h01, 8'h00);
    tick_check("s_t1", 8'h02, 8'h00);
    tick_check("s_t2b", 8'h04, 8'h00);
    tick_check("s_t3b", 8'h08, 8'h00);
    bus.timing_OUT = 8'hFF;
    tick_check("se_t0", 8'h01, 8'h00);
    tick_check("t0_ign", 8'h02, 8'h00);
    bus.timing_OUT = 8'h00;

    // Read stall holds T2, write "stall" does not
    tick_check("st_t2", 8'h04, 8'h00);
    bus.sig_RDY = 1'b0;
    for (int i = 0; i < 3; i++) tick_check("st_hold", 8'h04, 8'h00);
    bus.sig_RDY = 1'b1;
    tick_check("st_t3", 8'h08, 8'h00);
    bus.sig_RDY     = 1'b0;
    bus.sig_R_NOT_W = 1'b0;
    tick_check("wr_t4", 8'h10, 8'h00);
    tick_check("wr_t5", 8'h20, 8'h00);
    tick_check("wr_t6", 8'h40, 8'h00);
    bus.sig_RDY     = 1'b1;
    bus.sig_R_NOT_W = 1'b1;
    tick_check("wr_t0", 8'h01, 8'h00);

    // IRQ taken, then masked
    bus.irq_n  = 1'b0;
    bus.flag_I = 1'b0;
    tick_check("irq_t1", 8'h82, 8'h0A);
    bus.irq_n      = 1'b1;
    bus.timing_OUT = 8'h01;
    tick_check("irq_t0", 8'h81, 8'h0A);
    bus.timing_OUT = 8'h00;
    bus.irq_n      = 1'b0;
    bus.flag_I     = 1'b1;
    tick_check("irq_msk", 8'h02, 8'h00);

    // NMI edge plus active IRQ: NMI first, IRQ at next decision, held NMI once only
    bus.timing_OUT = 8'h01;
    bus.nmi_n      = 1'b0;
    bus.flag_I     = 1'b0;
    tick_check("pr_t0", 8'h01, 8'h00);
    bus.timing_OUT = 8'h00;
    tick_check("pr_nmi", 8'h82, 8'h09);
    bus.timing_OUT = 8'h01;
    tick_check("pr_nmi0", 8'h81, 8'h09);
    bus.timing_OUT = 8'h00;
    tick_check("pr_irq", 8'h82, 8'h0A);
    bus.timing_OUT = 8'h01;
    tick_check("pr_irq0", 8'h81, 8'h0A);
    bus.timing_OUT = 8'h00;
    bus.irq_n      = 1'b1;
    bus.flag_I     = 1'b1;
    tick_check("nmi_once", 8'h02, 8'h00);

    // NMI falling on the decision edge itself is deferred to the next decision
    bus.nmi_n      = 1'b1;
    bus.timing_OUT = 8'h01;
    tick_check("nd_t0", 8'h01, 8'h00);
    bus.timing_OUT = 8'h00;
    bus.nmi_n      = 1'b0;
    tick_check("nd_now", 8'h02, 8'h00);
    bus.timing_OUT = 8'h01;
    tick_check("nd_t0b", 8'h01, 8'h00);
    bus.timing_OUT = 8'h00;
    tick_check("nd_take", 8'h82, 8'h09);

    // Reset in the middle of T4 aborts the sequence
    tick_check("mr_t2", 8'h84, 8'h09);
    tick_check("mr_t3", 8'h88, 8'h09);
    tick_check("mr_t4", 8'h90, 8'h09);
    rst_n = 1'b0;
    tick_check("mr_rst", 8'h01, 8'h00);
    rst_n = 1'b1;
    tick_check("mr_rel", 8'h82, 8'h0C);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
